act_stream_feeder: RTL and testbench
====================================

# act_stream_feeder

Inter-layer activation buffer for the streamed MNIST pipeline. It captures the serialized 8-bit activations emitted one per cycle by an upstream processing unit into a ping-pong buffer. It then replays each completed bank into the downstream processing unit as a `mac_en`/`din` stream with matching weight addresses. After a fixed drain interval it issues the single-cycle `relu_en` pulse that makes the downstream unit quantize and serialize its accumulators.

## Interface
- `DATA_WIDTH`, 8: activation width (signed).
- `DEPTH`, 128: entries per bank, equal to the upstream unit's MAC count.
- `DRAIN_CYCLES`, 3: idle cycles between the last `mac_en_o` and `relu_en_o`. This covers the downstream 2-cycle `acc_en` delay plus 1 cycle of margin.
- `clk_i` in 1: the only clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: `in_data_i` holds a valid activation.
- `in_data_i` in DATA_WIDTH: upstream activation (signed).
- `in_done_i` in 1: upstream layer-complete pulse; closes the current write bank.
- `pu_done_i` in 1: downstream unit finished serializing; releases the read bank.
- `mac_en_o` out 1: downstream accumulate enable.
- `din_o` out DATA_WIDTH: activation aligned with `mac_en_o`.
- `waddr_o` out $clog2(DEPTH): weight index aligned with `mac_en_o`, counting 0..len-1.
- `relu_en_o` out 1: single-cycle start pulse to the downstream unit.
- `busy_o` out 1: high in every read state except IDLE.
- `ovf_o` out 1: sticky; a byte arrived while the target bank was still full.
- `len_err_o` out 1: sticky; a bank was closed by `in_done_i` with count ≠ DEPTH.

## Operation
- **Storage:** two banks of DEPTH × DATA_WIDTH, with per-bank `full[b]` and length `len[b]`. Write pointer `wr_bank` and read pointer `rd_bank` both reset to 0.
- **Write side (every cycle):**
  - `in_valid_i` with `!full[wr_bank]`: store at `wr_cnt`, then `wr_cnt++`.
  - `in_valid_i` with `full[wr_bank]`: drop the byte, set `ovf_o`.
  - The bank closes when the write makes `wr_cnt` reach DEPTH, or on `in_done_i` with `wr_cnt > 0`.
  - On close: `full[wr_bank]←1`, `len←count`, `wr_cnt←0`, toggle `wr_bank`.
  - `in_done_i` with `wr_cnt == 0` is ignored; empty banks never close.
  - `in_valid_i` and `in_done_i` in the same cycle: the byte is written first, then the bank closes including it.
  - `len_err_o` is set when `in_done_i` closes a bank with count ≠ DEPTH.
- **Read FSM states:** IDLE, STREAM, DRAIN, FIRE, WAIT_PU.
  - **IDLE:** `full[rd_bank]` → STREAM with `rd_idx←0`.
  - **STREAM:** read entry `rd_idx`, `rd_idx++`. After issuing index `len-1` → DRAIN, with `drain_cnt←DRAIN_CYCLES-1`.
  - **DRAIN:** count down; at 0 → FIRE.
  - **FIRE:** `relu_en_o=1` for exactly one cycle → WAIT_PU.
  - **WAIT_PU:** on `pu_done_i`, `full[rd_bank]←0`, toggle `rd_bank` → IDLE.
  - `pu_done_i` outside WAIT_PU is ignored.
- **Same-cycle events:**
  - A bank closing and the other bank being released in the same cycle are both honoured.
  - Write-side close and read-side release on the same bank in the same cycle cannot occur, because the pointers differ whenever both banks are in use.
- **Outputs:**
  - `din_o`, `waddr_o` and `mac_en_o` are registered; `din_o`/`waddr_o` hold their last value when `mac_en_o=0`.
  - `relu_en_o`, `busy_o`, `ovf_o` and `len_err_o` are registered or derived from registered state only.

## Timing
- **Reset:** all outputs 0; `full`, counters, pointers and FSM (IDLE) cleared asynchronously. Reset mid-stream aborts the stream, and no `relu_en_o` is produced.
- **Read memory:** synchronous, 1-cycle read latency. `mac_en_o` first rises 2 cycles after the `clk_i` edge that sets `full[rd_bank]`.
- **STREAM:** `mac_en_o` stays high for exactly `len` consecutive cycles, with no bubbles.
- **`relu_en_o`:** rises DRAIN_CYCLES+1 cycles after the last `mac_en_o` cycle.
- **Throughput:** write accepts 1 byte/cycle, with no backpressure. A second full bank waits in IDLE until release.

## Structure
- **Shared package `act_feeder_pkg`:** read FSM state enum, `ADDR_W = $clog2(DEPTH)`, `DEPTH` and `DRAIN_CYCLES` defaults.
- **Sub-module `act_bank_ram`:** 2×DEPTH simple dual-port RAM, 1 write port and 1 synchronous read port. Address is `{bank, idx}`, so it infers block RAM.
- **Top level:** write-side counter, read FSM and output registers.

## Test plan
- **Single bank:** 128 bytes 0x00..0x7F on consecutive cycles, then `in_done_i`.
  - Expect 128 cycles of `mac_en_o`, with `din_o` and `waddr_o` both 0..127.
  - Expect `relu_en_o` 4 cycles after the last `mac_en_o`, and `len_err_o=0`.
- **Short frame:** 10 bytes, then `in_done_i`.
  - Expect exactly 10 `mac_en_o` cycles and `len_err_o=1`.
- **Ping-pong:** 256 bytes back-to-back, `pu_done_i` withheld.
  - Bank 1 fills without `ovf_o`; its stream starts within 2 cycles of `pu_done_i`.
- **Overflow:** both banks full, then a 257th byte (0x55).
  - Expect `ovf_o=1` and 0x55 never appearing on `din_o`.
- **Reset during STREAM:** assert reset at `waddr_o=50`.
  - Expect all outputs 0 immediately, no `relu_en_o`, and a fresh 128-byte frame streaming correctly afterwards.
- **Same-cycle valid and done:** `in_valid_i` and `in_done_i` together on the 5th byte.
  - Expect `len=5`.

Source files
------------

// File: rtl/act_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_feeder_pkg
// Description : Shared constants and read-FSM state type for the inter-layer
//               activation feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package act_feeder_pkg;

    // Default geometry: one bank holds one full upstream layer output.
    localparam int C_DATA_WIDTH   = 8;
    localparam int C_DEPTH        = 128;
    localparam int C_DRAIN_CYCLES = 3;
    localparam int C_ADDR_W       = $clog2(C_DEPTH);

    // Read-side sequencing: replay a bank, let the downstream pipe settle,
    // pulse relu, then hold the bank until the downstream unit is done.
    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_STREAM  = 3'd1,
        RD_DRAIN   = 3'd2,
        RD_FIRE    = 3'd3,
        RD_WAIT_PU = 3'd4
    } rd_state_t;

endpackage : act_feeder_pkg
`default_nettype wire

// File: rtl/act_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : act_bank_ram
// Description : Two-bank activation store, one write port and one synchronous
//               read port. Address is {bank, index}.
// Revision    : 1.0 - initial release
// ============================================================================
module act_bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         we_i,
    input  logic [$clog2(DEPTH):0]       waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic                         re_i,
    input  logic [$clog2(DEPTH):0]       raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [0:2*DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates on a read, so the last value is held between streams.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule : act_bank_ram
`default_nettype wire

// File: rtl/act_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : act_stream_feeder
// Description : Ping-pong activation buffer. Captures the upstream byte stream
//               into alternating banks and replays each closed bank into the
//               downstream unit as mac_en/din/waddr, followed by relu_en.
// Revision    : 1.0 - initial release
// ============================================================================
module act_stream_feeder
    import act_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = C_DATA_WIDTH,
    parameter int DEPTH        = C_DEPTH,
    parameter int DRAIN_CYCLES = C_DRAIN_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       in_valid_i,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    input  logic                       in_done_i,
    input  logic                       pu_done_i,
    output logic                       mac_en_o,
    output logic [DATA_WIDTH-1:0]      din_o,
    output logic [$clog2(DEPTH)-1:0]   waddr_o,
    output logic                       relu_en_o,
    output logic                       busy_o,
    output logic                       ovf_o,
    output logic                       len_err_o
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   C_FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [DRAIN_W-1:0] C_DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    // ---------------- write side ----------------
    logic             r_wr_bank;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [1:0]       r_full;
    logic [CNT_W-1:0] r_len [2];
    logic             r_ovf;
    logic             r_len_err;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_close;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;

    // ---------------- read side ----------------
    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    logic                r_rd_bank;
    logic [ADDR_W-1:0]   r_rd_idx;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [CNT_W-1:0]    w_rd_len;
    logic                w_last;
    logic                w_release;
    logic                w_rd_en;

    logic                  r_mac_en;
    logic [ADDR_W-1:0]     r_waddr;
    logic                  r_relu_en;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A byte is stored only into a bank that is still open; the byte counts
    // toward the length before a same-cycle in_done closes the bank.
    assign w_accept  = in_valid_i & ~r_full[r_wr_bank];
    assign w_cnt_inc = r_wr_cnt + CNT_W'(w_accept);
    assign w_close   = (w_cnt_inc == C_FULL_CNT) | (in_done_i & (w_cnt_inc != '0));

    assign w_release  = (r_state == RD_WAIT_PU) & pu_done_i;
    assign w_full_set = w_close   ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_release ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    assign w_rd_len = r_len[r_rd_bank];
    assign w_last   = ({1'b0, r_rd_idx} == (w_rd_len - CNT_W'(1)));
    assign w_rd_en  = (r_state == RD_STREAM);

    // Write counter, bank pointer, bank lengths and sticky error flags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_close) begin
                r_len[r_wr_bank] <= w_cnt_inc;
                r_wr_cnt         <= '0;
                r_wr_bank        <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= w_cnt_inc;
            end
            if (in_valid_i & r_full[r_wr_bank]) begin
                r_ovf <= 1'b1;
            end
            if (w_close & in_done_i & (w_cnt_inc != C_FULL_CNT)) begin
                r_len_err <= 1'b1;
            end
        end
    end

    // Bank occupancy: closing one bank and releasing the other may coincide.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RD_IDLE:    if (r_full[r_rd_bank])  w_state_nxt = RD_STREAM;
            RD_STREAM:  if (w_last)             w_state_nxt = RD_DRAIN;
            RD_DRAIN:   if (r_drain_cnt == '0)  w_state_nxt = RD_FIRE;
            RD_FIRE:                            w_state_nxt = RD_WAIT_PU;
            RD_WAIT_PU: if (pu_done_i)          w_state_nxt = RD_IDLE;
            default:                            w_state_nxt = RD_IDLE;
        endcase
    end

    // Read index, drain countdown and read bank pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_idx    <= '0;
            r_drain_cnt <= '0;
            r_rd_bank   <= 1'b0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    r_rd_idx <= '0;
                end
                RD_STREAM: begin
                    r_rd_idx <= r_rd_idx + ADDR_W'(1);
                    if (w_last) begin
                        r_drain_cnt <= C_DRAIN_LOAD;
                    end
                end
                RD_DRAIN: begin
                    if (r_drain_cnt != '0) begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Output registers aligned with the one-cycle RAM read latency.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mac_en  <= 1'b0;
            r_waddr   <= '0;
            r_relu_en <= 1'b0;
        end else begin
            r_mac_en  <= w_rd_en;
            r_relu_en <= (r_state == RD_FIRE);
            if (w_rd_en) begin
                r_waddr <= r_rd_idx;
            end
        end
    end

    act_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank_ram (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (w_accept),
        .waddr_i ({r_wr_bank, r_wr_cnt[ADDR_W-1:0]}),
        .wdata_i (in_data_i),
        .re_i    (w_rd_en),
        .raddr_i ({r_rd_bank, r_rd_idx}),
        .rdata_o (w_rdata)
    );

    assign mac_en_o  = r_mac_en;
    assign din_o     = w_rdata;
    assign waddr_o   = r_waddr;
    assign relu_en_o = r_relu_en;
    assign busy_o    = (r_state != RD_IDLE);
    assign ovf_o     = r_ovf;
    assign len_err_o = r_len_err;

endmodule : act_stream_feeder
`default_nettype wire

// File: tb/tb_act_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_stream_feeder
// Description : Self-checking bench for act_stream_feeder with a cycle-timed
//               behavioural reference model and directed + random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_stream_feeder;
    import act_feeder_pkg::*;

    localparam int DEPTH = C_DEPTH;
    localparam int AW    = C_ADDR_W;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [7:0]    in_data_i = 8'h00;
    logic          in_done_i = 1'b0;
    logic          pu_done_i = 1'b0;
    logic          mac_en_o;
    logic [7:0]    din_o;
    logic [AW-1:0] waddr_o;
    logic          relu_en_o;
    logic          busy_o;
    logic          ovf_o;
    logic          len_err_o;

    act_stream_feeder #(
        .DATA_WIDTH   (8),
        .DEPTH        (DEPTH),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_done_i  (in_done_i),
        .pu_done_i  (pu_done_i),
        .mac_en_o   (mac_en_o),
        .din_o      (din_o),
        .waddr_o    (waddr_o),
        .relu_en_o  (relu_en_o),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o),
        .len_err_o  (len_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Banks are byte arrays; the read side is described by the edge at which
    // streaming of a bank begins (s): mac_en in the cycles after edges s+1..s+len,
    // relu after edge s+len+4, release accepted from edge s+len+5 on.
    bit         m_full[2];
    bit         full_pre[2];
    int         m_len[2];
    logic [7:0] m_frame[2][DEPTH];
    logic [7:0] m_rdata[DEPTH];
    int         m_cnt, m_wr, m_rd, m_s, m_rlen, n_edge, k_off;
    bit         m_active;
    bit         e_mac, e_relu, e_busy, e_ovf, e_lenerr;
    int         e_din, e_waddr;

    initial begin
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) begin
                m_full[0] = 0; m_full[1] = 0;
                m_cnt = 0; m_wr = 0; m_rd = 0; m_active = 0;
                e_mac = 0; e_relu = 0; e_busy = 0; e_ovf = 0; e_lenerr = 0;
                e_din = 0; e_waddr = 0;
            end else begin
                n_edge++;
                full_pre = m_full;
                if (m_active) begin
                    if (pu_done_i && n_edge >= m_s + m_rlen + 5) begin
                        m_full[m_rd] = 0;
                        m_rd ^= 1;
                        m_active = 0;
                    end
                end else if (full_pre[m_rd]) begin
                    m_active = 1;
                    m_s      = n_edge;
                    m_rlen   = m_len[m_rd];
                    for (int i = 0; i < DEPTH; i++) m_rdata[i] = m_frame[m_rd][i];
                end
                if (in_valid_i) begin
                    if (full_pre[m_wr]) e_ovf = 1;
                    else begin
                        m_frame[m_wr][m_cnt] = in_data_i;
                        m_cnt++;
                    end
                end
                if (m_cnt == DEPTH || (in_done_i && m_cnt > 0)) begin
                    if (in_done_i && m_cnt != DEPTH) e_lenerr = 1;
                    m_full[m_wr] = 1;
                    m_len[m_wr]  = m_cnt;
                    m_cnt = 0;
                    m_wr ^= 1;
                end
                e_mac  = 0;
                e_relu = 0;
                if (m_active) begin
                    k_off = n_edge - m_s;
                    if (k_off >= 1 && k_off <= m_rlen) begin
                        e_mac   = 1;
                        e_din   = m_rdata[k_off-1];
                        e_waddr = k_off - 1;
                    end
                    e_relu = (k_off == m_rlen + 4);
                end
                e_busy = m_active;
            end
        end
    end

    // ---------------- per-cycle compare and observation counters ----------------
    int cyc = 0, mac_cnt = 0, relu_cnt = 0, last_mac = 0, relu_gap = 0, seen55 = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            chk("mac_en",  mac_en_o,  e_mac);
            chk("din",     din_o,     e_din);
            chk("waddr",   waddr_o,   e_waddr);
            chk("relu_en", relu_en_o, e_relu);
            chk("busy",    busy_o,    e_busy);
            chk("ovf",     ovf_o,     e_ovf);
            chk("len_err", len_err_o, e_lenerr);
            if (mac_en_o) begin
                mac_cnt++;
                last_mac = cyc;
                if (din_o == 8'h55) seen55++;
            end
            if (relu_en_o) begin
                relu_cnt++;
                relu_gap = cyc - last_mac;
            end
        end
    end

    // ---------------- downstream unit stand-in ----------------
    bit auto_pu = 1, pu_noise = 0, man_pu = 0;
    int pu_cnt = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            begin
                bit p;
                p = man_pu;
                if (auto_pu) begin
                    if (pu_cnt > 0) begin
                        pu_cnt--;
                        if (pu_cnt == 0) p = 1;
                    end else if (relu_en_o) begin
                        pu_cnt = $urandom_range(1, 5);
                    end
                    if (pu_noise && $urandom_range(0, 15) == 0) p = 1;
                end
                pu_done_i = p;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send_byte(input logic [7:0] d, input bit done);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_done_i  = done;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_done_i  = 1'b0;
    endtask

    task automatic send_done();
        in_done_i = 1'b1;
        @(posedge clk_i); #1;
        in_done_i = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_pu();
        man_pu = 1'b1;
        @(posedge clk_i); #1;
        man_pu = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy_o || m_full[0] || m_full[1]) && k < budget) begin
            @(posedge clk_i); #1;
            k++;
        end
        idle(2);
        chk("idle_timeout", int'(k < budget), 1);
    endtask

    task automatic wait_relu(input int target, input int budget);
        int k;
        k = 0;
        while (relu_cnt < target && k < budget) begin
            @(posedge clk_i); #1;
            k++;
        end
        chk("relu_timeout", int'(k < budget), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int r0, k, flen;
        #1 rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("reset_mac_en", mac_en_o, 0);
        chk("reset_busy",   busy_o,   0);

        // Single full bank 0x00..0x7F.
        mac_cnt = 0; relu_cnt = 0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        send_done();
        wait_idle(2000);
        chk("t1_mac_cycles", mac_cnt,   128);
        chk("t1_relu_gap",   relu_gap,  4);
        chk("t1_relu_count", relu_cnt,  1);
        chk("t1_len_err",    len_err_o, 0);
        chk("t1_last_waddr", waddr_o,   127);
        chk("t1_last_din",   din_o,     127);

        // Short frame of 10 bytes.
        mac_cnt = 0;
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_done();
        wait_idle(2000);
        chk("t2_mac_cycles", mac_cnt,   10);
        chk("t2_len_err",    len_err_o, 1);

        // Valid and done together on the 5th byte.
        mac_cnt = 0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte(8'hA5, 1'b1);
        wait_idle(2000);
        chk("t3_mac_cycles", mac_cnt, 5);

        // Ping-pong with release withheld, then an overflow byte.
        auto_pu = 0; mac_cnt = 0; seen55 = 0; r0 = relu_cnt;
        for (int i = 0; i < 2*DEPTH; i++) send_byte(8'h80 | 8'(i % 128), 1'b0);
        chk("t4_no_ovf", ovf_o, 0);
        send_byte(8'h55, 1'b0);
        chk("t4_ovf", ovf_o, 1);
        wait_relu(r0 + 1, 2000);
        idle(3);
        pulse_pu();
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!mac_en_o && k < 20);
        chk("t4_restart_latency", k, 3);
        @(posedge clk_i); #1;
        wait_relu(r0 + 2, 2000);
        pulse_pu();
        auto_pu = 1;
        wait_idle(2000);
        chk("t4_mac_cycles", mac_cnt, 256);
        chk("t4_no_0x55",    seen55,  0);

        // Reset in the middle of a stream.
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!(mac_en_o && waddr_o == 7'd50) && k < 1000);
        chk("t5_reach_50", int'(k < 1000), 1);
        #1 rstn_i = 1'b0;
        #1;
        chk("t5_rst_mac",     mac_en_o,  0);
        chk("t5_rst_din",     din_o,     0);
        chk("t5_rst_waddr",   waddr_o,   0);
        chk("t5_rst_relu",    relu_en_o, 0);
        chk("t5_rst_busy",    busy_o,    0);
        chk("t5_rst_ovf",     ovf_o,     0);
        chk("t5_rst_len_err", len_err_o, 0);
        r0 = relu_cnt;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        idle(10);
        chk("t5_no_relu", relu_cnt, r0);
        mac_cnt = 0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        wait_idle(2000);
        chk("t5_fresh_mac_cycles", mac_cnt, 128);

        // Random frames, gaps, stray pu_done pulses.
        pu_noise = 1;
        for (int f = 0; f < 16; f++) begin
            flen = $urandom_range(1, DEPTH);
            for (int i = 0; i < flen; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_byte(8'($urandom_range(0, 255)),
                          (i == flen - 1) && (flen < DEPTH) && ($urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 2) == 0) send_done();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 200));
        end
        send_done();
        pu_noise = 0;
        wait_idle(8000);
        chk("final_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_act_stream_feeder
`default_nettype wire
